// File: rtl/conv_top.sv
// conv_top: tile convolution controller, 8-lane 16-bit MAC over NIF*KX*KX taps per output group.
// Fetches pixel/weight words, accumulates in 40 bits per lane, writes one saturated word per group.
module conv_top #(
    parameter int NIF     = 4,
    parameter int KX      = 3,
    parameter int NOF_GRP = 2,
    parameter int LANES   = 8,
    parameter int DW      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES*DW-1:0]   input_pixels,
    input  logic [LANES*DW-1:0]   weights,
    input  logic                  ready,
    input  logic                  valid,
    output logic [LANES*DW-1:0]   output_pixels,
    output logic                  read_en,
    output logic                  write_en,
    output logic [31:0]           bram_rd_addr,
    output logic [31:0]           bram_wr_addr,
    output logic                  tile_pof_done,
    output logic                  tile_done
);
    localparam int TAPS = NIF * KX * KX;
    localparam int SW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int GW   = (NOF_GRP > 1) ? $clog2(NOF_GRP) : 1;
    localparam int AW   = 40;
    localparam logic signed [AW-1:0] SMAX = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = -SMAX - 1;

    typedef enum logic [1:0] {IDLE, READ, ACC, WRITE} state_t;

    state_t state, next;
    logic [SW-1:0] step;
    logic [GW-1:0] grp;
    logic signed [AW-1:0] acc [LANES];
    logic [LANES*DW-1:0] sat, held;
    logic last_step, last_grp, restart;

    assign last_step    = step == SW'(TAPS - 1);
    assign last_grp     = grp == GW'(NOF_GRP - 1);
    assign restart      = (state == IDLE && ready) || (state == WRITE && !last_grp);
    assign bram_rd_addr = 32'(grp) * 32'(TAPS) + 32'(step);
    assign bram_wr_addr = 32'(grp);
    // The result word is live combinationally during WRITE so it lines up with write_en.
    assign output_pixels = (state == WRITE) ? sat : held;

    always_comb begin
        for (int i = 0; i < LANES; i++)
            sat[i*DW +: DW] = (acc[i] > SMAX) ? SMAX[DW-1:0] :
                              (acc[i] < SMIN) ? SMIN[DW-1:0] : acc[i][DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next          = state;
        read_en       = 1'b0;
        write_en      = 1'b0;
        tile_pof_done = 1'b0;
        tile_done     = 1'b0;
        case (state)
            IDLE:  next = ready ? READ : IDLE;
            READ: begin
                read_en = 1'b1;
                next    = ACC;
            end
            ACC:   next = !valid ? ACC : last_step ? WRITE : READ;
            WRITE: begin
                write_en      = 1'b1;
                tile_pof_done = 1'b1;
                tile_done     = last_grp;
                next          = last_grp ? IDLE : READ;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step <= '0;
            grp  <= '0;
            held <= '0;
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else begin
            if (restart) begin
                step <= '0;
                grp  <= (state == IDLE) ? '0 : grp + 1'b1;
                for (int i = 0; i < LANES; i++) acc[i] <= '0;
            end
            if (state == ACC && valid) begin
                if (!last_step) step <= step + 1'b1;
                for (int i = 0; i < LANES; i++)
                    acc[i] <= acc[i] + AW'($signed(input_pixels[i*DW +: DW])) *
                                       AW'($signed(weights[i*DW +: DW]));
            end
            if (state == WRITE) held <= sat;
        end
    end
endmodule

// File: tb/tb_conv_top.sv
// tb_conv_top: directed tests for conv_top with hand-computed results and cycle counts.
module tb_conv_top;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] input_pixels, weights, output_pixels;
    logic         ready, valid, read_en, write_en, tile_pof_done, tile_done;
    logic [31:0]  bram_rd_addr, bram_wr_addr;

    int errors = 0;
    int checks = 0;

    logic [31:0]  rd_log [256];
    logic [31:0]  wr_addr_log [8];
    logic [127:0] wr_data_log [8];
    int n_rd, n_wr, n_pof, n_done, done_cyc, stall_bad;
    logic done_wr, timeout, rst_seen;
    logic [295:0] post_rst;

    localparam logic [127:0] ONES = {8{16'hFFFF}};
    localparam logic [127:0] R24  = {8{16'h0024}};
    localparam logic [127:0] PMAX = {8{16'h7FFF}};
    localparam logic [127:0] NMIN = {8{16'h8000}};

    conv_top dut (
        .clk(clk), .rst_n(rst_n), .input_pixels(input_pixels), .weights(weights),
        .ready(ready), .valid(valid), .output_pixels(output_pixels), .read_en(read_en),
        .write_en(write_en), .bram_rd_addr(bram_rd_addr), .bram_wr_addr(bram_wr_addr),
        .tile_pof_done(tile_pof_done), .tile_done(tile_done)
    );

    always #5 clk = ~clk;

    // Pulses ready, then observes one tile at negedges; cycle 1 is the first READ cycle.
    task automatic run_tile(input logic [127:0] pix, input logic [127:0] wt,
                            input int stall_addr, input int mid_rdy, input int rst_addr);
        int stall_left = 0;
        logic stalled = 1'b0;
        logic finished = 1'b0;
        n_rd = 0; n_wr = 0; n_pof = 0; n_done = 0; done_cyc = 0; stall_bad = 0;
        done_wr = 1'b0; timeout = 1'b0; rst_seen = 1'b0; post_rst = '1;
        input_pixels = pix; weights = wt; valid = 1'b1;
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            if (cyc > 1) @(negedge clk);
            ready = (cyc == mid_rdy);
            if (read_en && n_rd < 256) begin rd_log[n_rd] = bram_rd_addr; n_rd++; end
            if (write_en && n_wr < 8) begin
                wr_addr_log[n_wr] = bram_wr_addr; wr_data_log[n_wr] = output_pixels; n_wr++;
            end
            if (tile_pof_done) n_pof++;
            if (tile_done) begin n_done++; done_cyc = cyc; done_wr = write_en; finished = 1'b1; end
            if (stall_left > 0) begin
                if (bram_rd_addr !== 32'(stall_addr) || read_en) stall_bad++;
                stall_left--;
                valid = (stall_left == 0);
            end else if (stall_addr >= 0 && !stalled && !read_en && bram_rd_addr == 32'(stall_addr)) begin
                valid = 1'b0; stall_left = 5; stalled = 1'b1;
            end
            if (rst_addr >= 0 && read_en && bram_rd_addr == 32'(rst_addr)) begin
                rst_n = 1'b0;
                @(negedge clk);
                post_rst = {output_pixels, read_en, write_en, bram_rd_addr, bram_wr_addr, tile_pof_done, tile_done};
                rst_n = 1'b1; rst_seen = 1'b1; finished = 1'b1;
            end
        end
        ready = 1'b0; valid = 1'b1;
        if (!finished) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ready = 1'b1; valid = 1'b0; input_pixels = ONES; weights = ONES;
        repeat (2) @(negedge clk);
        ready = 1'b0;
        checks++;
        if ({output_pixels, read_en, write_en, bram_rd_addr, bram_wr_addr, tile_pof_done, tile_done} !== '0) begin
            errors++; $display("FAIL reset_outputs: got out=%h rd=%0d wr=%0d re=%b we=%b, want all 0",
                               output_pixels, bram_rd_addr, bram_wr_addr, read_en, write_en);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({output_pixels, read_en, write_en, bram_rd_addr, tile_done} !== '0) begin
            errors++; $display("FAIL reset_idle: got re=%b we=%b rd=%0d out=%h, want idle zeros",
                               read_en, write_en, bram_rd_addr, output_pixels);
        end
    endtask

    task automatic test_all_ones();
        run_tile(ONES, ONES, -1, -1, -1);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL ones_timeout: no tile_done in budget"); end
        checks++;
        if (n_rd !== 72) begin errors++; $display("FAIL ones_nreads: got %0d want 72", n_rd); end
        for (int i = 0; i < 72 && i < n_rd; i++) begin
            checks++;
            if (rd_log[i] !== 32'(i)) begin errors++; $display("FAIL ones_rdaddr[%0d]: got %0d want %0d", i, rd_log[i], i); end
        end
        checks++;
        if (n_wr !== 2) begin errors++; $display("FAIL ones_nwrites: got %0d want 2", n_wr); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wr_addr_log[i] !== 32'(i)) begin errors++; $display("FAIL ones_wraddr[%0d]: got %0d want %0d", i, wr_addr_log[i], i); end
            checks++;
            if (wr_data_log[i] !== R24) begin errors++; $display("FAIL ones_data[%0d]: got %h want %h", i, wr_data_log[i], R24); end
        end
        checks++;
        if (n_pof !== 2) begin errors++; $display("FAIL ones_pof: got %0d want 2", n_pof); end
        checks++;
        if (n_done !== 1 || done_wr !== 1'b1) begin errors++; $display("FAIL ones_done: got n=%0d with_write=%b want 1/1", n_done, done_wr); end
        checks++;
        if (done_cyc !== 146) begin errors++; $display("FAIL ones_latency: got %0d want 146", done_cyc); end
        repeat (3) @(negedge clk);
        checks++;
        if (output_pixels !== R24 || write_en !== 1'b0) begin
            errors++; $display("FAIL ones_hold: got out=%h we=%b want %h we=0", output_pixels, write_en, R24);
        end
    endtask

    task automatic test_saturation();
        run_tile(PMAX, PMAX, -1, -1, -1);
        checks++;
        if (wr_data_log[0] !== PMAX || wr_data_log[1] !== PMAX || n_wr !== 2) begin
            errors++; $display("FAIL sat_pos: got %h/%h n=%0d want %h", wr_data_log[0], wr_data_log[1], n_wr, PMAX);
        end
        run_tile(NMIN, PMAX, -1, -1, -1);
        checks++;
        if (wr_data_log[0] !== NMIN || wr_data_log[1] !== NMIN || n_wr !== 2) begin
            errors++; $display("FAIL sat_neg: got %h/%h n=%0d want %h", wr_data_log[0], wr_data_log[1], n_wr, NMIN);
        end
    endtask

    task automatic test_stall();
        run_tile(ONES, ONES, 10, -1, -1);
        checks++;
        if (stall_bad !== 0) begin errors++; $display("FAIL stall_addr_hold: got %0d bad cycles want 0", stall_bad); end
        checks++;
        if (done_cyc !== 151) begin errors++; $display("FAIL stall_latency: got %0d want 151", done_cyc); end
        checks++;
        if (n_rd !== 72) begin errors++; $display("FAIL stall_nreads: got %0d want 72", n_rd); end
        checks++;
        if (wr_data_log[0] !== R24 || wr_data_log[1] !== R24) begin
            errors++; $display("FAIL stall_data: got %h/%h want %h", wr_data_log[0], wr_data_log[1], R24);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 2; t++) begin
            run_tile(ONES, ONES, -1, 50, -1);
            checks++;
            if (n_rd !== 72 || rd_log[0] !== 32'd0 || rd_log[71] !== 32'd71) begin
                errors++; $display("FAIL b2b_addrs[%0d]: got n=%0d first=%0d last=%0d want 72/0/71", t, n_rd, rd_log[0], rd_log[71]);
            end
            checks++;
            if (done_cyc !== 146 || n_done !== 1) begin
                errors++; $display("FAIL b2b_latency[%0d]: got %0d n=%0d want 146/1", t, done_cyc, n_done);
            end
            checks++;
            if (wr_data_log[1] !== R24 || wr_addr_log[1] !== 32'd1) begin
                errors++; $display("FAIL b2b_data[%0d]: got %h @%0d want %h @1", t, wr_data_log[1], wr_addr_log[1], R24);
            end
        end
    endtask

    task automatic test_mid_reset();
        run_tile(NMIN, PMAX, -1, -1, -1);
        run_tile(ONES, ONES, -1, -1, 20);
        checks++;
        if (rst_seen !== 1'b1 || n_wr !== 0) begin errors++; $display("FAIL midrst_reached: got seen=%b writes=%0d want 1/0", rst_seen, n_wr); end
        checks++;
        if (post_rst !== '0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", post_rst); end
        run_tile(ONES, ONES, -1, -1, -1);
        checks++;
        if (done_cyc !== 146 || n_rd !== 72 || rd_log[0] !== 32'd0) begin
            errors++; $display("FAIL midrst_clean: got lat=%0d n=%0d first=%0d want 146/72/0", done_cyc, n_rd, rd_log[0]);
        end
        checks++;
        if (wr_data_log[0] !== R24 || wr_data_log[1] !== R24) begin
            errors++; $display("FAIL midrst_data: got %h/%h want %h", wr_data_log[0], wr_data_log[1], R24);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_saturation();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv_top.md
Name: conv_top

Overview:
- Tile-level convolution controller with an 8-lane, 16-bit multiply-accumulate datapath.
- On a start pulse it walks NIF input channels × KX×KX kernel taps for each of NOF_GRP output-feature-map groups.
- It fetches pixel and weight words from BRAM, accumulates per lane, and writes one 128-bit result word per group.
- It sits between the feature/weight BRAMs and the output BRAM.

Parameters:
- NIF, 4, input feature maps per tile.
- KX, 3, kernel width and height (KX×KX taps).
- NOF_GRP, 2, output-feature-map groups per tile.
- LANES, 8, parallel MAC lanes.
- DW, 16, lane data width; bus width is LANES*DW = 128.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- input_pixels  in  128  8 signed 16-bit pixels; lane i is bits [16i+15:16i].
- weights  in  128  8 signed 16-bit weights, same lane packing.
- ready  in  1  start pulse; sampled only in IDLE.
- valid  in  1  read-data-valid qualifier for input_pixels/weights.
- output_pixels  out  128  8 saturated signed 16-bit results.
- read_en  out  1  BRAM read request.
- write_en  out  1  BRAM write strobe.
- bram_rd_addr  out  32  read address, shared by pixel and weight BRAMs.
- bram_wr_addr  out  32  write address.
- tile_pof_done  out  1  one-cycle pulse when a group is written.
- tile_done  out  1  one-cycle pulse when the last group is written.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - All outputs 0.
  - Accumulators, step and group counters cleared.
  - Reset mid-tile aborts the tile; no write occurs.
- States: IDLE, READ, ACC, WRITE.
- IDLE:
  - ready=1 → clear accumulators, step=0, grp=0, go to READ.
  - ready=0 → stay.
- READ (1 cycle):
  - read_en=1.
  - bram_rd_addr = grp*NIF*KX*KX + step.
  - Next state ACC.
- ACC:
  - read_en=0; bram_rd_addr holds.
  - If valid=0: stay (stall indefinitely).
  - If valid=1: acc[i] += sext(pixel_i)*sext(weight_i), full 32-bit signed product, 40-bit signed accumulator.
  - Then if step < NIF*KX*KX-1: step++, go to READ.
  - Else go to WRITE.
- WRITE (1 cycle):
  - write_en=1.
  - bram_wr_addr = grp.
  - output_pixels lane i = acc[i] saturated to [-32768, 32767].
  - tile_pof_done=1.
  - If grp = NOF_GRP-1: tile_done=1 in the same cycle, go to IDLE.
  - Otherwise grp++, step=0, clear accumulators, go to READ.
- output_pixels holds its last written value until the next WRITE or reset.
- write_en, read_en, tile_pof_done and tile_done are 0 outside the states above.
- ready while not in IDLE is ignored. A new ready in IDLE after tile_done restarts from addresses 0.
- Latency with valid tied high:
  - 2 cycles per tap plus 1 write cycle per group.
  - One group takes 2*NIF*KX*KX+1 = 73 cycles; a full tile takes 146 cycles from the ready sample to the tile_done cycle (defaults).
- Simultaneous ready with reset: reset wins.

Test Plan:
- Reset: hold rst_n=0 for 1 cycle → all outputs 0, state IDLE; ready while rst_n=0 has no effect.
- All-ones data (input_pixels=weights=128'hFF..F), valid=1, ready pulse:
  - Each lane computes (-1)*(-1) summed 36 times, so every lane of output_pixels = 16'h0024.
  - write_en pulses at wr_addr 0, then at wr_addr 1.
  - tile_pof_done pulses twice; tile_done pulses once, with the second write.
  - read addresses run 0..71.
- Saturation: all pixels 16'h7FFF, weights 16'h7FFF → every lane = 16'h7FFF; pixels 16'h8000, weights 16'h7FFF → every lane = 16'h8000.
- Stall: drop valid for 5 cycles during ACC at step 10 → bram_rd_addr holds at 10, no accumulation; results unchanged (0x0024), tile latency +5.
- Back-to-back tiles: second ready pulse after tile_done → identical address sequence from 0 and identical results; ready pulses mid-tile are ignored.
- Mid-tile reset at step 20 → outputs 0 immediately; a later ready produces a clean full tile.
